// File: rtl/datapath_processador_if.sv
// Bus and control bundle between the control unit (master) and the datapath (slave).
// Define DATAPATH_ZERO_FLAG_EN to add the Zero flag signal.
interface datapath_processador_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] DIN;
  logic [7:0]        Rin;
  logic [7:0]        Rout;
  logic              IncrPc;
  logic              IRin;
  logic              ADDRin;
  logic              DOUTin;
  logic              W_D;
  logic              Ain;
  logic              Gin;
  logic              Gout;
  logic              DINout;
  logic [1:0]        Ulaop;
  logic [DATA_W-1:0] Bus;
  logic [DATA_W-1:0] ADDR;
  logic [DATA_W-1:0] DOUT;
  logic              W;
  logic [8:0]        Instrucao;
  logic [DATA_W-1:0] GRout;
`ifdef DATAPATH_ZERO_FLAG_EN
  logic              Zero;
`endif

  modport master (
    output DIN, Rin, Rout, IncrPc, IRin, ADDRin, DOUTin, W_D, Ain, Gin, Gout, DINout, Ulaop,
    input  Bus, ADDR, DOUT, W, Instrucao, GRout
`ifdef DATAPATH_ZERO_FLAG_EN
    , input Zero
`endif
  );

  modport slave (
    input  DIN, Rin, Rout, IncrPc, IRin, ADDRin, DOUTin, W_D, Ain, Gin, Gout, DINout, Ulaop,
    output Bus, ADDR, DOUT, W, Instrucao, GRout
`ifdef DATAPATH_ZERO_FLAG_EN
    , output Zero
`endif
  );
endinterface

// File: rtl/datapath_processador.sv
// Simple processor datapath: R0..R7 (R0 = PC), A, G, IR, ADDR, DOUT, W around a shared bus.
// Optional Zero flag register enabled by the DATAPATH_ZERO_FLAG_EN macro.
module datapath_processador #(
  parameter int DATA_W = 16
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  datapath_processador_if.slave  dp
);

  logic [DATA_W-1:0] r [8];
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic              w_q;
  logic [8:0]        ir;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu;
  logic              found;

  function automatic logic [DATA_W-1:0] alu_op(input logic [DATA_W-1:0] lhs,
                                               input logic [DATA_W-1:0] rhs,
                                               input logic [1:0]        op);
    logic signed [DATA_W-1:0] sl;
    logic signed [DATA_W-1:0] sr;
    sl = lhs;
    sr = rhs;
    case (op)
      2'b00:   return lhs + rhs;
      2'b01:   return lhs - rhs;
      2'b10:   return lhs & rhs;
      default: return (sl < sr) ? DATA_W'(1) : '0;
    endcase
  endfunction

  // Bus source: DIN, then G, then the lowest-indexed enabled register.
  always_comb begin
    bus   = '0;
    found = 1'b0;
    if (dp.DINout) begin
      bus = dp.DIN;
    end else if (dp.Gout) begin
      bus = g;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (dp.Rout[i] && !found) begin
          bus   = r[i];
          found = 1'b1;
        end
      end
    end
  end

  assign alu = alu_op(a, bus, dp.Ulaop);

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      for (int i = 0; i < 8; i++) r[i] <= '0;
      a      <= '0;
      g      <= '0;
      ir     <= '0;
      addr_q <= '0;
      dout_q <= '0;
      w_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (dp.Rin[i]) r[i] <= bus;
      end
      // An explicit PC load takes precedence over the increment.
      if (dp.IncrPc && !dp.Rin[0]) r[0] <= r[0] + DATA_W'(1);
      if (dp.Ain)    a      <= bus;
      if (dp.Gin)    g      <= alu;
      if (dp.IRin)   ir     <= bus[8:0];
      if (dp.ADDRin) addr_q <= bus;
      if (dp.DOUTin) dout_q <= bus;
      w_q <= dp.W_D;
    end
  end

`ifdef DATAPATH_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      zero_q <= 1'b0;
    end else if (dp.Gin) begin
      zero_q <= (alu == '0);
    end
  end

  assign dp.Zero = zero_q;
`endif

  assign dp.Bus       = bus;
  assign dp.ADDR      = addr_q;
  assign dp.DOUT      = dout_q;
  assign dp.W         = w_q;
  assign dp.Instrucao = ir;
  assign dp.GRout     = g;

endmodule

// File: tb/tb_datapath_processador.sv
// Table-driven bench for datapath_processador with a queue of expected post-edge register state.
module tb_datapath_processador;

  logic Clock = 1'b0;
  logic Resetn;

  datapath_processador_if #(.DATA_W(16)) dp();
  datapath_processador #(.DATA_W(16)) dut (.Clock(Clock), .Resetn(Resetn), .dp(dp));

  always #5 Clock = ~Clock;

  localparam logic [8:0] C_INCR = 9'h100, C_IR  = 9'h080, C_ADDR = 9'h040,
                         C_DOUT = 9'h020, C_WD  = 9'h010, C_AIN  = 9'h008,
                         C_GIN  = 9'h004, C_GOUT = 9'h002, C_DIN = 9'h001;

  typedef struct packed {
    logic        rst;
    logic [15:0] din;
    logic [7:0]  rin;
    logic [7:0]  rout;
    logic [8:0]  ctl;
    logic [1:0]  op;
    logic        chk_bus;
    logic [15:0] exp_bus;
    logic        chk_post;
    logic [15:0] exp_g;
    logic [15:0] exp_addr;
    logic [15:0] exp_dout;
    logic        exp_w;
    logic [8:0]  exp_ir;
  } vec_t;

  typedef struct packed {
    logic [15:0] g;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic [8:0]  ir;
  } post_t;

  post_t sb[$];
  vec_t  tbl[$];
  int    checks = 0;
  int    passed = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [15:0] din, input logic [7:0] rin, input logic [7:0] rout,
                              input logic [8:0] ctl, input logic [1:0] op, input logic [15:0] eb,
                              input logic [15:0] pg, input logic [15:0] pa, input logic [15:0] pd,
                              input logic pw, input logic [8:0] pir);
    vec_t v;
    v = '0;
    v.din = din; v.rin = rin; v.rout = rout; v.ctl = ctl; v.op = op;
    v.chk_bus = 1'b1; v.exp_bus = eb;
    v.chk_post = 1'b1; v.exp_g = pg; v.exp_addr = pa; v.exp_dout = pd; v.exp_w = pw; v.exp_ir = pir;
    return v;
  endfunction

  function automatic vec_t vb(input logic [15:0] din, input logic [7:0] rin, input logic [7:0] rout,
                              input logic [8:0] ctl, input logic [1:0] op, input logic [15:0] eb);
    vec_t v;
    v = mk(din, rin, rout, ctl, op, eb, 16'h0, 16'h0, 16'h0, 1'b0, 9'h0);
    v.chk_post = 1'b0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    Resetn    = v.rst;
    dp.DIN    = v.din;
    dp.Rin    = v.rin;
    dp.Rout   = v.rout;
    dp.IncrPc = v.ctl[8];
    dp.IRin   = v.ctl[7];
    dp.ADDRin = v.ctl[6];
    dp.DOUTin = v.ctl[5];
    dp.W_D    = v.ctl[4];
    dp.Ain    = v.ctl[3];
    dp.Gin    = v.ctl[2];
    dp.Gout   = v.ctl[1];
    dp.DINout = v.ctl[0];
    dp.Ulaop  = v.op;
  endtask

  task automatic apply(input vec_t v, input string name);
    post_t p;
    @(negedge Clock);
    drive(v);
    #1;
    if (v.chk_bus) chk({name, " bus"}, dp.Bus, v.exp_bus);
    if (v.chk_post) sb.push_back({v.exp_g, v.exp_addr, v.exp_dout, v.exp_w, v.exp_ir});
    @(posedge Clock);
    #1;
    while (sb.size() > 0) begin
      p = sb.pop_front();
      chk({name, " GRout"},     dp.GRout, p.g);
      chk({name, " ADDR"},      dp.ADDR,  p.addr);
      chk({name, " DOUT"},      dp.DOUT,  p.dout);
      chk({name, " W"},         16'(dp.W), 16'(p.w));
      chk({name, " Instrucao"}, 16'(dp.Instrucao), 16'(p.ir));
    end
  endtask

  initial begin
    vec_t v;

    // Main table: state carried from one row to the next.
    tbl.push_back(mk(16'h1234, 8'h04, 8'h00, C_DIN,         2'd0, 16'h1234, 16'h0000, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h0000, 8'h00, 8'h04, 9'h0,          2'd0, 16'h1234, 16'h0000, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h0005, 8'h02, 8'h00, C_DIN,         2'd0, 16'h0005, 16'h0000, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h0007, 8'h04, 8'h00, C_DIN,         2'd0, 16'h0007, 16'h0000, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h0000, 8'h00, 8'h02, C_AIN,         2'd0, 16'h0005, 16'h0000, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h0000, 8'h00, 8'h04, C_GIN,         2'd1, 16'h0007, 16'hFFFE, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'hAAAA, 8'h00, 8'h06, C_DIN | C_GOUT, 2'd0, 16'hAAAA, 16'hFFFE, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'hAAAA, 8'h00, 8'h06, C_GOUT,        2'd0, 16'hFFFE, 16'hFFFE, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'hAAAA, 8'h00, 8'h06, 9'h0,          2'd0, 16'h0005, 16'hFFFE, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h0000, 8'h00, 8'h04, C_GIN,         2'd0, 16'h0007, 16'h000C, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h0006, 8'h00, 8'h00, C_DIN | C_GIN, 2'd2, 16'h0006, 16'h0004, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'hFFFF, 8'h00, 8'h00, C_DIN | C_GIN, 2'd3, 16'hFFFF, 16'h0000, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h0010, 8'h00, 8'h00, C_DIN | C_GIN, 2'd3, 16'h0010, 16'h0001, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h8000, 8'h00, 8'h00, C_DIN | C_AIN, 2'd0, 16'h8000, 16'h0001, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h0000, 8'h00, 8'h00, C_DIN | C_GIN, 2'd3, 16'h0000, 16'h0001, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h0001, 8'h00, 8'h00, C_DIN | C_GIN, 2'd1, 16'h0001, 16'h7FFF, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h0010, 8'h01, 8'h00, C_DIN,         2'd0, 16'h0010, 16'h7FFF, 16'h0, 16'h0, 1'b0, 9'h0));
    tbl.push_back(mk(16'h0000, 8'h00, 8'h01, C_ADDR | C_DOUT | C_WD, 2'd0, 16'h0010, 16'h7FFF, 16'h0010, 16'h0010, 1'b1, 9'h0));
    tbl.push_back(mk(16'h01C9, 8'h00, 8'h00, C_DIN | C_IR,  2'd0, 16'h01C9, 16'h7FFF, 16'h0010, 16'h0010, 1'b0, 9'h1C9));
    tbl.push_back(mk(16'h0000, 8'h00, 8'h00, C_GOUT,        2'd0, 16'h7FFF, 16'h7FFF, 16'h0010, 16'h0010, 1'b0, 9'h1C9));
    tbl.push_back(mk(16'h0000, 8'h00, 8'h00, 9'h0,          2'd0, 16'h0000, 16'h7FFF, 16'h0010, 16'h0010, 1'b0, 9'h1C9));

    v = vb(16'h0, 8'h0, 8'h0, 9'h0, 2'd0, 16'h0);
    v.rst = 1'b1;
    drive(v);
    repeat (2) @(posedge Clock);
    #1;
    chk("reset GRout",     dp.GRout, 16'h0);
    chk("reset ADDR",      dp.ADDR, 16'h0);
    chk("reset DOUT",      dp.DOUT, 16'h0);
    chk("reset W",         16'(dp.W), 16'h0);
    chk("reset Instrucao", 16'(dp.Instrucao), 16'h0);
    chk("reset Bus",       dp.Bus, 16'h0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));
`ifdef DATAPATH_ZERO_FLAG_EN
    chk("zero after 7FFF", 16'(dp.Zero), 16'h0);
`endif

    // PC wrap, load-over-increment, pre-increment bus value
    apply(vb(16'hFFFF, 8'h01, 8'h00, C_DIN,          2'd0, 16'hFFFF), "pc_load");
    apply(vb(16'h0000, 8'h00, 8'h00, C_INCR,         2'd0, 16'h0000), "pc_incr");
    apply(vb(16'h0000, 8'h00, 8'h01, 9'h0,           2'd0, 16'h0000), "pc_wrap");
    apply(vb(16'h0040, 8'h01, 8'h00, C_DIN | C_INCR, 2'd0, 16'h0040), "pc_ld_incr");
    apply(vb(16'h0000, 8'h00, 8'h01, C_INCR,         2'd0, 16'h0040), "pc_pre_incr");
    apply(vb(16'h0000, 8'h00, 8'h01, 9'h0,           2'd0, 16'h0041), "pc_post_incr");

    // Several Rin bits at once, untouched neighbour, priority among Rout bits
    apply(vb(16'hBEEF, 8'h30, 8'h00, C_DIN, 2'd0, 16'hBEEF), "multi_ld");
    apply(vb(16'h0000, 8'h00, 8'h10, 9'h0,  2'd0, 16'hBEEF), "r4");
    apply(vb(16'h0000, 8'h00, 8'h20, 9'h0,  2'd0, 16'hBEEF), "r5");
    apply(vb(16'h0000, 8'h00, 8'h08, 9'h0,  2'd0, 16'h0000), "r3");
    apply(vb(16'h0000, 8'h00, 8'h24, 9'h0,  2'd0, 16'h0007), "prio_r2_r5");

    // Reset overriding every enable in the same cycle
    v = mk(16'h5555, 8'hFF, 8'h00, C_DIN | C_AIN | C_GIN | C_IR | C_ADDR | C_DOUT | C_WD, 2'd0,
           16'h5555, 16'h0, 16'h0, 16'h0, 1'b0, 9'h0);
    v.rst = 1'b1;
    apply(v, "rst_mid");
`ifdef DATAPATH_ZERO_FLAG_EN
    chk("zero after reset", 16'(dp.Zero), 16'h0);
`endif
    for (int i = 0; i < 8; i++)
      apply(mk(16'h0, 8'h0, 8'(1 << i), 9'h0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 9'h0),
            $sformatf("rst_r%0d", i));
    apply(mk(16'h0003, 8'h00, 8'h00, C_DIN | C_GIN, 2'd0, 16'h0003, 16'h0003, 16'h0, 16'h0, 1'b0, 9'h0),
          "rst_a_zero");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
